alu_share_arbiter: RTL and testbench

//  Shares the single ArithmeticLogicUnit between NREQ independent requesters
//  (e.g. execute stage, branch/address unit, debug port) under a round-robin policy.

---
 rtl/alu_share_arbiter_pkg.sv | 32 +++
 rtl/ArithmeticLogicUnit.sv | 37 +++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/alu_share_arbiter.sv | 131 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : alu_share_arbiter_pkg
// Brief   : ALU op codes, arbiter state encodings and sizing helper.
// Rev     : 1.0  initial release
// ============================================================================
package alu_share_arbiter_pkg;

   localparam logic [3:0] aluAdd  = 4'd0;
   localparam logic [3:0] aluSub  = 4'd1;
   localparam logic [3:0] aluAnd  = 4'd2;
   localparam logic [3:0] aluOr   = 4'd3;
   localparam logic [3:0] aluXor  = 4'd4;
   localparam logic [3:0] aluNor  = 4'd5;
   localparam logic [3:0] aluShl  = 4'd6;
   localparam logic [3:0] aluShr  = 4'd7;
   localparam logic [3:0] aluSlt  = 4'd8;
   localparam logic [3:0] aluSltu = 4'd9;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_RESP  = 2'd2
   } arb_state_t;

   // Requester id width; a single requester still gets a 1-bit id.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ArithmeticLogicUnit.sv
`default_nettype none
// ============================================================================
// Module : ArithmeticLogicUnit
// Brief  : Combinational integer ALU, wrapping arithmetic, no flags.
// Rev    : 1.0  initial release
// ============================================================================
module ArithmeticLogicUnit
   import alu_share_arbiter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       ctrl,
   output logic [WIDTH-1:0] result
);

   always_comb begin
      result = '0;
      case (ctrl)
         aluAdd:  result = a + b;
         aluSub:  result = a - b;
         aluAnd:  result = a & b;
         aluOr:   result = a | b;
         aluXor:  result = a ^ b;
         aluNor:  result = ~(a | b);
         // Full-width shift amount: anything >= WIDTH shifts everything out.
         aluShl:  result = a << b;
         aluShr:  result = a >> b;
         aluSlt:  result = WIDTH'($signed(a) < $signed(b));
         aluSltu: result = WIDTH'(a < b);
         default: result = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick: first request at or above ptr, wrapping.
// Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IDW  = id_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_id
);

   int   w_idx;
   logic w_found;

   always_comb begin
      grant    = '0;
      grant_id = '0;
      w_found  = 1'b0;
      w_idx    = 0;
      for (int off = 0; off < NREQ; off++) begin
         w_idx = int'(ptr) + off;
         if (w_idx >= NREQ) begin
            w_idx = w_idx - NREQ;
         end
         if (!w_found && req[w_idx]) begin
            grant[w_idx] = 1'b1;
            grant_id     = IDW'(w_idx);
            w_found      = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module : alu_share_arbiter
// Brief  : Round-robin sharing of one ALU among NREQ valid/ready requesters.
// Rev    : 1.0  initial release
// ============================================================================
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ*4-1:0]     req_ctrl,
   output logic [NREQ-1:0]       resp_valid,
   input  logic [NREQ-1:0]       resp_ready,
   output logic [WIDTH-1:0]      resp_data,
   output logic                  busy
);

   localparam int IDW = id_width(NREQ);

   arb_state_t       r_state;
   arb_state_t       w_state_nxt;
   logic [IDW-1:0]   r_ptr;
   logic [IDW-1:0]   r_id;
   logic [IDW-1:0]   w_grant_id;
   logic [IDW-1:0]   w_ptr_nxt;
   logic [NREQ-1:0]  w_grant;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [3:0]       r_ctrl;
   logic [WIDTH-1:0] r_resp_data;
   logic [WIDTH-1:0] w_alu_result;
   logic             w_accept;
   logic             w_done;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr (
      .req      (req_valid),
      .ptr      (r_ptr),
      .grant    (w_grant),
      .grant_id (w_grant_id)
   );

   ArithmeticLogicUnit #(
      .WIDTH (WIDTH)
   ) u_alu (
      .a      (r_a),
      .b      (r_b),
      .ctrl   (r_ctrl),
      .result (w_alu_result)
   );

   assign w_ptr_nxt = (r_id == IDW'(NREQ - 1)) ? '0 : r_id + IDW'(1);
   assign resp_data = r_resp_data;

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = '0;
      resp_valid  = '0;
      busy        = 1'b0;
      w_accept    = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            // Gated by reset_n so req_ready reads zero while reset is held.
            if (|req_valid && reset_n) begin
               req_ready   = w_grant;
               w_accept    = 1'b1;
               w_state_nxt = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            busy        = 1'b1;
            w_state_nxt = ARB_RESP;
         end
         ARB_RESP: begin
            busy             = 1'b1;
            resp_valid[r_id] = 1'b1;
            if (resp_ready[r_id]) begin
               w_done      = 1'b1;
               w_state_nxt = ARB_IDLE;
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ARB_IDLE;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         // Pointer moves only when the owner takes its result.
         if (w_done) begin
            r_ptr <= w_ptr_nxt;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_a         <= '0;
         r_b         <= '0;
         r_ctrl      <= '0;
         r_id        <= '0;
         r_resp_data <= '0;
      end else begin
         if (w_accept) begin
            r_a    <= req_a[w_grant_id*WIDTH +: WIDTH];
            r_b    <= req_b[w_grant_id*WIDTH +: WIDTH];
            r_ctrl <= req_ctrl[w_grant_id*4 +: 4];
            r_id   <= w_grant_id;
         end
         if (r_state == ARB_ISSUE) begin
            r_resp_data <= w_alu_result;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_share_arbiter
// Brief  : Directed bench with a transaction-level model of the shared ALU.
// Rev    : 1.0  initial release
// ============================================================================
module tb_alu_share_arbiter;
   import alu_share_arbiter_pkg::*;

   localparam int NREQ = 2;
   localparam int W    = 32;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a = '0;
   logic [NREQ*W-1:0] req_b = '0;
   logic [NREQ*4-1:0] req_ctrl = '0;
   logic [NREQ-1:0]   resp_valid;
   logic [NREQ-1:0]   resp_ready = '0;
   logic [W-1:0]      resp_data;
   logic              busy;

   int errors = 0;
   int checks = 0;

   alu_share_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ctrl   (req_ctrl),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: at most one transaction outstanding, result visible one cycle after accept.
   bit           m_inflight = 1'b0;
   int           m_age = 0;
   int           m_id = 0;
   int           m_ptr = 0;
   logic [W-1:0] m_res = '0;
   int           dut_grants[NREQ];
   int           grant_log[$];
   logic [NREQ-1:0] exp_ready;
   logic [NREQ-1:0] exp_valid;
   int           g;

   function automatic int pick(input logic [NREQ-1:0] v, input int p);
      for (int off = 0; off < NREQ; off++) begin
         if (v[(p + off) % NREQ]) return (p + off) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [3:0] op);
      case (op)
         aluAdd:  return a + b;
         aluSub:  return a - b;
         aluAnd:  return a & b;
         aluOr:   return a | b;
         aluXor:  return a ^ b;
         aluNor:  return ~(a | b);
         aluShl:  return (b >= 32) ? '0 : a << b[4:0];
         aluShr:  return (b >= 32) ? '0 : a >> b[4:0];
         aluSlt:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         aluSltu: return (a < b) ? 32'd1 : 32'd0;
         default: return '0;
      endcase
   endfunction

   always @(negedge clk) begin
      if (!reset_n) begin
         check("rst_req_ready", req_ready, 0);
         check("rst_resp_valid", resp_valid, 0);
         check("rst_busy", busy, 0);
         check("rst_resp_data", resp_data, 0);
         m_inflight = 1'b0;
         m_age      = 0;
         m_ptr      = 0;
      end else begin
         exp_ready = '0;
         exp_valid = '0;
         g = -1;
         if (!m_inflight) begin
            g = pick(req_valid, m_ptr);
            if (g >= 0) exp_ready[g] = 1'b1;
         end else if (m_age >= 1) begin
            exp_valid[m_id] = 1'b1;
         end
         check("model_req_ready", req_ready, exp_ready);
         check("model_resp_valid", resp_valid, exp_valid);
         check("model_busy", busy, m_inflight);
         if (exp_valid != 0) check("model_resp_data", resp_data, m_res);
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               dut_grants[i]++;
               grant_log.push_back(i);
            end
         end
         if (!m_inflight) begin
            if (g >= 0) begin
               m_inflight = 1'b1;
               m_age      = 0;
               m_id       = g;
               m_res      = alu_ref(req_a[g*W +: W], req_b[g*W +: W], req_ctrl[g*4 +: 4]);
            end
         end else if (m_age >= 1 && resp_ready[m_id]) begin
            m_inflight = 1'b0;
            m_ptr      = (m_id + 1) % NREQ;
         end else begin
            m_age++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] op);
      req_a[i*W +: W]    = a;
      req_b[i*W +: W]    = b;
      req_ctrl[i*4 +: 4] = op;
      req_valid[i]       = 1'b1;
   endtask

   task automatic do_op(input string name, input int id, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [3:0] op, input logic [W-1:0] exp);
      int n;
      set_req(id, a, b, op);
      #1;
      n = 0;
      while (!req_ready[id] && n < 20) begin
         step();
         n++;
      end
      check({name, "_grant_timeout"}, n >= 20, 0);
      step();
      req_valid[id] = 1'b0;
      n = 0;
      while (!resp_valid[id] && n < 20) begin
         step();
         n++;
      end
      check({name, "_resp_timeout"}, n >= 20, 0);
      check({name, "_data"}, resp_data, exp);
      resp_ready[id] = 1'b1;
      step();
      resp_ready[id] = 1'b0;
   endtask

   initial begin
      int cyc;
      repeat (3) step();
      reset_n = 1'b1;
      check("reset_resp_data", resp_data, 0);
      check("reset_busy", busy, 0);

      // Single subtract from requester 0
      set_req(0, 32'd5, 32'd3, aluSub);
      #1;
      check("t1_req_ready", req_ready, 2'b01);
      step();
      req_valid = '0;
      step();
      check("t1_resp_valid", resp_valid, 2'b01);
      check("t1_resp_data", resp_data, 32'd2);
      repeat (3) step();
      check("t1_hold_valid", resp_valid, 2'b01);
      check("t1_hold_data", resp_data, 32'd2);
      resp_ready = 2'b01;
      step();
      resp_ready = '0;
      check("t1_done_valid", resp_valid, 2'b00);
      check("t1_done_busy", busy, 0);

      // Contention: both requesters always valid
      dut_grants[0] = 0;
      dut_grants[1] = 0;
      grant_log.delete();
      set_req(0, 32'd100, 32'd1, aluAdd);
      set_req(1, 32'd7, 32'd9, aluXor);
      resp_ready = 2'b11;
      cyc = 0;
      while ((dut_grants[0] + dut_grants[1]) < 20 && cyc < 200) begin
         step();
         cyc++;
      end
      check("t2_timeout", cyc >= 200, 0);
      req_valid = '0;
      repeat (3) step();
      resp_ready = '0;
      check("t2_grants_req0", dut_grants[0], 10);
      check("t2_grants_req1", dut_grants[1], 10);
      check("t2_first_grant", grant_log[0], 1);
      check("t2_second_grant", grant_log[1], 0);
      check("t2_third_grant", grant_log[2], 1);

      // Backpressure on requester 1 while requester 0 waits
      set_req(1, 32'h0000_1234, 32'd4, aluShl);
      resp_ready = 2'b01;
      #1;
      check("t3_req_ready", req_ready, 2'b10);
      step();
      set_req(0, 32'd1, 32'd1, aluAdd);
      step();
      for (int k = 0; k < 10; k++) begin
         check("t3_resp_valid", resp_valid, 2'b10);
         check("t3_resp_data", resp_data, 32'h0001_2340);
         check("t3_req_ready_blocked", req_ready, 2'b00);
         check("t3_busy", busy, 1);
         step();
      end
      req_valid[1] = 1'b0;
      resp_ready = 2'b11;
      step();
      check("t3_req0_granted", req_ready, 2'b01);
      step();
      req_valid = '0;
      step();
      check("t3_req0_valid", resp_valid, 2'b01);
      check("t3_req0_data", resp_data, 32'd2);
      step();
      resp_ready = '0;

      // Operation sweep
      do_op("t4_add_wrap", 0, 32'hFFFF_FFFF, 32'd1, aluAdd, 32'h0000_0000);
      do_op("t4_or", 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, aluOr, 32'hFFF0_FFF0);
      do_op("t4_and", 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, aluAnd, 32'h00F0_00F0);
      do_op("t4_xor", 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, aluXor, 32'hFF00_FF00);
      do_op("t4_nor", 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, aluNor, 32'h000F_000F);
      do_op("t4_shl", 0, 32'd1, 32'd31, aluShl, 32'h8000_0000);
      do_op("t4_shr", 0, 32'h8000_0000, 32'd31, aluShr, 32'h0000_0001);
      do_op("t4_shl_32", 1, 32'hFFFF_FFFF, 32'd32, aluShl, 32'h0000_0000);
      do_op("t4_sub_wrap", 1, 32'd0, 32'd1, aluSub, 32'hFFFF_FFFF);

      // Reset while an op is in ISSUE
      set_req(1, 32'd10, 32'd20, aluAdd);
      #1;
      step();
      set_req(0, 32'd50, 32'd8, aluSub);
      #1;
      reset_n = 1'b0;
      #1;
      check("t5_async_req_ready", req_ready, 2'b00);
      check("t5_async_resp_valid", resp_valid, 2'b00);
      check("t5_async_busy", busy, 0);
      check("t5_async_resp_data", resp_data, 0);
      repeat (2) step();
      reset_n = 1'b1;
      #1;
      check("t5_grant_req0", req_ready, 2'b01);
      step();
      req_valid = '0;
      step();
      step();
      check("t5_resp_valid", resp_valid, 2'b01);
      check("t5_resp_data", resp_data, 32'd42);
      resp_ready = 2'b01;
      step();
      resp_ready = '0;
      check("t5_done_busy", busy, 0);

      repeat (2) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
